// File: rtl/mips_regfile.sv
// 32-entry MIPS register file with write-through bypass and ALU flag capture.
// Register 0 is hardwired to zero; reads are combinational.
module mips_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_en,
  input  logic              z_in,
  input  logic              n_in,
  output logic              z_q,
  output logic              n_q,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_act;

  assign wr_act = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_act) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (flag_en) begin
      z_q <= z_in;
      n_q <= n_in;
    end
  end

  // Bypass lets a consumer see this cycle's write result without a stall.
  function automatic logic [DATA_W-1:0] rd_port(
    input logic              rstn,
    input logic [ADDR_W-1:0] a,
    input logic              wact,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (!rstn) begin
      r = '0;
    end else if (a == '0) begin
      r = '0;
    end else if (wact && (wa == a)) begin
      r = wd;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  always_comb begin
    rd_data1 = rd_port(rst_n, rs_addr, wr_act, wr_addr, wr_data,
                       regs_q[rs_addr]);
  end

  always_comb begin
    rd_data2 = rd_port(rst_n, rt_addr, wr_act, wr_addr, wr_data,
                       regs_q[rt_addr]);
  end

  always_comb begin
    dbg_data = rd_port(rst_n, dbg_addr, wr_act, wr_addr, wr_data,
                       regs_q[dbg_addr]);
  end

endmodule
